// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch/decode/execute sequencing,
// datapath select and write-enable generation, flag register and branch resolution.
module instruction_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] memoryData,
  input  logic [4:0]  aluFlags,
  output logic [15:0] instruction,
  output logic        blockRamWriteEnable,
  output logic        registerFileWriteEnable,
  output logic [1:0]  integerTypeSelectionLine,
  output logic        reg2OrImmediateSelectionLine,
  output logic        pcOrRegisterSelectionLine,
  output logic        addressFromRegOrDecoderSelectionLine,
  output logic        writeBackToRegRamOrALUSelectionLine,
  output logic        pcOrAluOutputRamReadSelectionLine,
  output logic [15:0] decoderRamWriteAddress,
  output logic        pcWriteEnable,
  output logic [1:0]  pcSourceSelect,
  output logic [4:0]  flags,
  output logic        halted
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned F_C    = 4;
  localparam int unsigned F_L    = 3;
  localparam int unsigned F_Z    = 1;
  localparam int unsigned F_N    = 0;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMWAIT, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_RALU, K_IALU, K_LOAD, K_STOR, K_JUMP, K_BRANCH, K_HALT, K_NOP
  } kind_t;

  typedef struct packed {
    logic       bram_we;
    logic       rf_we;
    logic [1:0] int_sel;
    logic       imm_sel;
    logic       reg1_sel;
    logic       addr_sel;
    logic       wb_sel;
    logic       pc_addr_sel;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  function automatic kind_t decode_kind(input logic [DATA_W-1:0] ir);
    kind_t k;
    case (ir[15:12])
      4'b0000: k = K_RALU;
      4'b0100: begin
        case (ir[7:4])
          4'b0000: k = K_LOAD;
          4'b0100: k = K_STOR;
          4'b1100: k = K_JUMP;
          default: k = K_NOP;
        endcase
      end
      4'b1100: k = K_BRANCH;
      4'b1110: k = K_HALT;
      default: k = K_IALU;
    endcase
    return k;
  endfunction

  function automatic logic cond_met(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
    logic r;
    case (cond)
      4'b0000: r = f[F_Z];
      4'b0001: r = ~f[F_Z];
      4'b0010: r = f[F_C];
      4'b0011: r = ~f[F_C];
      4'b0100: r = f[F_L];
      4'b0101: r = ~f[F_L];
      4'b0110: r = f[F_N];
      4'b0111: r = ~f[F_N];
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ADD, SUB and CMP (register or immediate form) are the only flag writers.
  function automatic logic sets_flags(input logic [DATA_W-1:0] ir);
    logic [3:0] code;
    code = (ir[15:12] == 4'b0000) ? ir[7:4] : ir[15:12];
    return (code == 4'b0101) || (code == 4'b1001) || (code == 4'b1011);
  endfunction

  state_t              state, state_nxt;
  logic                started;
  logic [DATA_W-1:0]   instr_nxt;
  logic [FLAG_W-1:0]   flags_nxt;
  ctrl_t               ctrl, ctrl_nxt;
  kind_t               kind_nxt;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_nxt = state;
    instr_nxt = instruction;
    flags_nxt = flags;
    ctrl_nxt  = '0;
    kind_nxt  = K_NOP;

    case (state)
      S_FETCH:   state_nxt = started ? S_DECODE : S_FETCH;
      S_DECODE: begin
        instr_nxt = memoryData;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (sets_flags(instruction)) flags_nxt = aluFlags;
        case (decode_kind(instruction))
          K_LOAD:  state_nxt = S_MEMWAIT;
          K_HALT:  state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMWAIT: state_nxt = S_FETCH;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_FETCH;
    endcase

    kind_nxt = decode_kind(instr_nxt);
    case (state_nxt)
      S_FETCH: ctrl_nxt.pc_addr_sel = 1'b1;
      S_EXECUTE: begin
        case (kind_nxt)
          K_RALU, K_IALU: begin
            ctrl_nxt.reg1_sel = 1'b1;
            ctrl_nxt.wb_sel   = 1'b1;
            ctrl_nxt.addr_sel = 1'b1;
            ctrl_nxt.rf_we    = 1'b1;
            ctrl_nxt.pc_we    = 1'b1;
            if (kind_nxt == K_IALU) begin
              ctrl_nxt.imm_sel = 1'b1;
              // Logical immediates (op 1..3) zero-extend, arithmetic ones sign-extend.
              ctrl_nxt.int_sel = (instr_nxt[15:14] == 2'b00) ? 2'b10 : 2'b01;
            end
          end
          K_STOR: begin
            ctrl_nxt.bram_we = 1'b1;
            ctrl_nxt.pc_we   = 1'b1;
          end
          K_BRANCH: begin
            ctrl_nxt.pc_we  = 1'b1;
            ctrl_nxt.pc_src = cond_met(instr_nxt[11:8], flags) ? 2'b01 : 2'b00;
          end
          K_JUMP: begin
            ctrl_nxt.pc_we  = 1'b1;
            ctrl_nxt.pc_src = cond_met(instr_nxt[11:8], flags) ? 2'b10 : 2'b00;
          end
          K_NOP:   ctrl_nxt.pc_we = 1'b1;
          default: ctrl_nxt = '0;
        endcase
      end
      S_MEMWAIT: begin
        ctrl_nxt.addr_sel = 1'b1;
        ctrl_nxt.rf_we    = 1'b1;
        ctrl_nxt.pc_we    = 1'b1;
      end
      S_HALT:  ctrl_nxt.halted = 1'b1;
      default: ctrl_nxt = '0;
    endcase
  end

  // State, instruction, flag and control registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      started     <= 1'b0;
      instruction <= '0;
      flags       <= '0;
      ctrl        <= '0;
    end else begin
      state       <= state_nxt;
      started     <= 1'b1;
      instruction <= instr_nxt;
      flags       <= flags_nxt;
      ctrl        <= ctrl_nxt;
    end
  end

  assign blockRamWriteEnable                  = ctrl.bram_we;
  assign registerFileWriteEnable              = ctrl.rf_we;
  assign integerTypeSelectionLine             = ctrl.int_sel;
  assign reg2OrImmediateSelectionLine         = ctrl.imm_sel;
  assign pcOrRegisterSelectionLine            = ctrl.reg1_sel;
  assign addressFromRegOrDecoderSelectionLine = ctrl.addr_sel;
  assign writeBackToRegRamOrALUSelectionLine  = ctrl.wb_sel;
  assign pcOrAluOutputRamReadSelectionLine    = ctrl.pc_addr_sel;
  assign pcWriteEnable                        = ctrl.pc_we;
  assign pcSourceSelect                       = ctrl.pc_src;
  assign halted                               = ctrl.halted;
  assign decoderRamWriteAddress               = DATA_W'(instruction[11:8]);

endmodule
